// File: rtl/shift_arbiter_pkg.sv
// Shared types and widths for the shift_arbiter block: FSM state encoding and
// the operand/shift-amount widths of the shared shifter.
package shift_arbiter_pkg;

  localparam int SHIFT_W = 8;
  localparam int SHAMT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_RESP
  } shift_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester after 'last', wrapping
// modulo N_REQ, so the previous winner has lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last) + off) % N_REQ;
      if (!any && valid[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shifter8.sv
// Existing 8-bit logical left shifter: zero fill, bits shifted out are lost.
module shifter8 (
  input  logic [7:0] a,
  input  logic [2:0] shamt,
  output logic [7:0] y
);

  assign y = a << shamt;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one shifter8 between N_REQ requesters, with operand and
// result registers around the shifter. SHIFT_ARBITER_STATS_EN adds per-requester grant counters.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [SHIFT_W*N_REQ-1:0] req_data,
  input  logic [SHAMT_W*N_REQ-1:0] req_shamt,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SHIFT_W-1:0]       res_data,
  output logic [ID_W-1:0]          res_id,
`ifdef SHIFT_ARBITER_STATS_EN
  output logic [CNT_W*N_REQ-1:0]   stat_grants,
`endif
  output shift_arb_state_t         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is a grant, raised only in IDLE, one-hot, and may depend on req_valid.

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("shift_arbiter: N_REQ must be in 2..8");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("shift_arbiter: CNT_W must be at least 1");
  end

  shift_arb_state_t   state_q, state_d;
  logic [SHIFT_W-1:0] op_q, op_d;
  logic [SHAMT_W-1:0] sh_q, sh_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [SHIFT_W-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic               res_valid_q, res_valid_d;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any;
  logic [SHIFT_W-1:0] shift_y;
  logic               accept;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .valid     (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  shifter8 u_shifter (
    .a     (op_q),
    .shamt (sh_q),
    .y     (shift_y)
  );

  // Grant is held low while reset is asserted so no requester sees a phantom accept.
  assign accept = (state_q == S_IDLE) && !rst && any;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sh_d        = sh_q;
    id_d        = id_q;
    last_d      = last_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    req_ready   = '0;
    case (state_q)
      S_IDLE: begin
        if (!rst) req_ready = grant;
        if (accept) begin
          op_d    = req_data[SHIFT_W*int'(grant_idx) +: SHIFT_W];
          sh_d    = req_shamt[SHAMT_W*int'(grant_idx) +: SHAMT_W];
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_data_d  = shift_y;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      sh_q        <= '0;
      id_q        <= '0;
      last_q      <= ID_W'(N_REQ - 1);
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sh_q        <= sh_d;
      id_q        <= id_d;
      last_q      <= last_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign dbg_state = state_q;

`ifdef SHIFT_ARBITER_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating: a counter parked at all-ones stays there until reset.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q[grant_idx] != '1)) begin
      cnt_d[grant_idx] = cnt_q[grant_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stat_grants = cnt_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed bench for shift_arbiter against a transaction-level
// round-robin/shift model with an expected-result queue.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int IW = 1;
  localparam int CW = 2;
  localparam int EW = 8 + IW;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [8*N-1:0]   req_data;
  logic [3*N-1:0]   req_shamt;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [IW-1:0]    res_id;
  shift_arb_state_t dbg_state;
`ifdef SHIFT_ARBITER_STATS_EN
  logic [CW*N-1:0]  stat_grants;
`endif

  shift_arbiter #(
    .N_REQ (N),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_shamt   (req_shamt),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_id      (res_id),
`ifdef SHIFT_ARBITER_STATS_EN
    .stat_grants (stat_grants),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: transaction-level view
  logic [EW-1:0] exp_q[$];
  int last_g;
  bit busy;
  int phase;
  int exp_cnt[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int off = 1; off <= N; off++) begin
      int i;
      i = (last + off) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    busy   = 1'b0;
    phase  = 0;
    last_g = N - 1;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
  endtask

  // driver
  task automatic set_req(input int i, input bit v, input logic [7:0] d, input logic [2:0] s);
    req_valid[i]      = v;
    req_data[8*i +: 8]  = d;
    req_shamt[3*i +: 3] = s;
  endtask

  task automatic check_stats(input string tag);
`ifdef SHIFT_ARBITER_STATS_EN
    for (int i = 0; i < N; i++)
      check($sformatf("%s_stat%0d", tag, i), 32'(stat_grants[CW*i +: CW]), exp_cnt[i]);
`else
    if (tag.len() == 0) $display("note: empty stats tag");
`endif
  endtask

  // One clock cycle: inputs already applied by the caller just after the last edge.
  task automatic cycle();
    int g;
    bit exp_rv, do_pop, do_acc;
    logic [N-1:0] exp_rdy;
    logic [7:0] a;
    logic [2:0] s;
    logic [EW-1:0] e_head, e_new;
    e_new = '0;
    @(negedge clk);
    exp_rv = busy && (phase >= 2);
    check("res_valid", 32'(res_valid), 32'(exp_rv));
    if (exp_rv) begin
      e_head = exp_q[0];
      check("res_data", 32'(res_data), 32'(e_head[7:0]));
      check("res_id", 32'(res_id), 32'(e_head[EW-1:8]));
    end
    g = busy ? -1 : rr_pick(last_g, req_valid);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("state", 32'(dbg_state), !busy ? 32'(S_IDLE) : (phase == 1 ? 32'(S_SHIFT) : 32'(S_RESP)));
    check_stats("run");
    do_pop = exp_rv && res_ready;
    do_acc = (g >= 0);
    if (do_acc) begin
      a = req_data[8*g +: 8];
      s = req_shamt[3*g +: 3];
      e_new = {IW'(g), 8'((int'(a) * (1 << s)) % 256)};
    end
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(exp_q.pop_front());
      busy = 1'b0;
    end
    if (busy) phase++;
    if (do_acc) begin
      exp_q.push_back(e_new);
      busy   = 1'b1;
      phase  = 1;
      last_g = g;
      if (exp_cnt[g] < (1 << CW) - 1) exp_cnt[g]++;
    end
  endtask

  // Async reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_res_id"}, 32'(res_id), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    check_stats(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0] bnd_d [3] = '{8'hA5, 8'hFF, 8'h80};
  logic [2:0] bnd_s [3] = '{3'd0, 3'd7, 3'd1};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_shamt = '0;
    res_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;

    // single request, 3 << 2
    set_req(0, 1'b1, 8'b0000_0011, 3'd2);
    res_ready = 1'b1;
    cycle();
    set_req(0, 1'b0, 8'h00, 3'd0);
    repeat (3) cycle();

    // both requesters continuously valid: grants must alternate
    set_req(0, 1'b1, 8'h01, 3'd1);
    set_req(1, 1'b1, 8'h81, 3'd7);
    repeat (12) cycle();
    req_valid = '0;
    repeat (2) cycle();

    // backpressure while a result is held
    set_req(1, 1'b1, 8'h5A, 3'd3);
    res_ready = 1'b0;
    cycle();
    set_req(1, 1'b0, 8'h00, 3'd0);
    set_req(0, 1'b1, 8'h33, 3'd4);
    repeat (7) cycle();
    res_ready = 1'b1;
    repeat (4) cycle();
    req_valid = '0;
    repeat (2) cycle();

    // shift boundaries
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, bnd_d[k], bnd_s[k]);
      cycle();
      req_valid = '0;
      repeat (2) cycle();
    end

    // reset during SHIFT, then during RESP; next grant must go to requester 0
    set_req(0, 1'b1, 8'h11, 3'd1);
    set_req(1, 1'b1, 8'h22, 3'd2);
    res_ready = 1'b1;
    cycle();
    mid_reset("mid_shift");
    repeat (4) cycle();
    res_ready = 1'b0;
    repeat (3) cycle();
    mid_reset("mid_resp");
    res_ready = 1'b1;
    repeat (4) cycle();
    req_valid = '0;
    repeat (2) cycle();

    // repeated accepts for requester 1 (counter saturation when stats are built in)
    mid_reset("pre_stats");
    set_req(1, 1'b1, 8'h0F, 3'd2);
    repeat (16) cycle();
    req_valid = '0;
    repeat (2) cycle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
